demux4_collector_16bit: RTL and testbench

Four-slot 16-bit holding stage directly downstream of the 4-way 16-bit demux. Each word arrives tagged with its 2-bit route select and is parked in the slot that select addresses. Occupied slots are drained one word per handshake through a single output port. Slots are served round-robin, so that no route starves.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/rr_arbiter4.sv | 25 ++
 rtl/demux4_collector_16bit.sv | 98 +++++++++
 tb/tb_demux4_collector_16bit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 4-slot demux collector.
package demux_pkg;

  // Default data word width
  parameter int unsigned WIDTH = 16;

  // Route select width and slot count
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NSLOT = 4;

  // Number of set bits in a 4-bit occupancy vector
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter4 (
  input  logic [demux_pkg::NSLOT-1:0] req,
  input  logic [demux_pkg::SEL_W-1:0] ptr,
  output logic [demux_pkg::SEL_W-1:0] gnt,
  output logic                        any
);
  import demux_pkg::*;

  logic [SEL_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/demux4_collector_16bit.sv
// Four-slot holding stage behind the 4-way demux; drains one word per handshake
// round-robin, holding a presented word stable until it is accepted.
module demux4_collector_16bit #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [demux_pkg::SEL_W-1:0] in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [demux_pkg::SEL_W-1:0] out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [demux_pkg::NSLOT-1:0] slot_full,
  output logic [2:0]                  count
);
  import demux_pkg::*;

  logic [WIDTH-1:0] slot_q [NSLOT];
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;

  logic [SEL_W-1:0] arb_gnt;
  logic             arb_any;
  logic             wr_fire;
  logic             rd_fire;

  rr_arbiter4 u_arb (
    .req (valid_q),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // No bypass: a slot draining this cycle is still reported not ready
  assign in_ready = ~valid_q[in_sel];
  assign wr_fire  = in_valid & in_ready;

  // Present the locked slot while stalled, otherwise the round-robin pick
  always_comb begin
    out_valid = arb_any;
    out_sel   = '0;
    out_data  = '0;
    if (arb_any) begin
      out_sel  = lock_q ? lock_sel_q : arb_gnt;
      out_data = slot_q[out_sel];
    end
  end

  assign rd_fire   = out_valid & out_ready;
  assign slot_full = valid_q;
  assign count     = popcount4(valid_q);

  // Next-state for occupancy, pointer and lock; write and drain never hit the same slot
  always_comb begin
    valid_d    = valid_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (wr_fire) begin
      valid_d[in_sel] = 1'b1;
    end
    if (rd_fire) begin
      valid_d[out_sel] = 1'b0;
      rr_d             = out_sel + SEL_W'(1);
      lock_d           = 1'b0;
    end else if (out_valid) begin
      lock_d     = 1'b1;
      lock_sel_d = out_sel;
    end
  end

  // State registers; reset discards slots and lock and ignores that cycle's handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      if (wr_fire) begin
        slot_q[in_sel] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux4_collector_16bit.sv
// Bench for demux4_collector_16bit: directed table, corner sequences, random vs model.
module tb_demux4_collector_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  slot_full;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  demux4_collector_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot_full (slot_full),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot contents, presented slot held while stalled
  bit        m_full [4];
  bit [15:0] m_data [4];
  int        m_rr;
  bit        m_held;
  int        m_held_sel;
  bit        m_ov;
  int        m_osel;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0;
      m_data[i] = 0;
    end
    m_rr = 0;
    m_held = 0;
    m_held_sel = 0;
  endfunction

  function automatic void model_present();
    m_ov = 0;
    m_osel = 0;
    for (int i = 0; i < 4; i++) if (m_full[i]) m_ov = 1;
    if (m_ov) begin
      if (m_held) m_osel = m_held_sel;
      else begin
        for (int k = 3; k >= 0; k--) if (m_full[(m_rr + k) % 4]) m_osel = (m_rr + k) % 4;
      end
    end
  endfunction

  function automatic void model_step();
    bit wr;
    bit rd;
    if (rst) begin
      model_reset();
      return;
    end
    model_present();
    wr = in_valid && !m_full[in_sel];
    rd = m_ov && out_ready;
    if (wr) begin
      m_full[in_sel] = 1;
      m_data[in_sel] = in_data;
    end
    if (rd) begin
      m_full[m_osel] = 0;
      m_rr = (m_osel + 1) % 4;
      m_held = 0;
    end else if (m_ov) begin
      m_held = 1;
      m_held_sel = m_osel;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    bit [3:0] f;
    n = 0;
    model_present();
    for (int i = 0; i < 4; i++) begin
      f[i] = m_full[i];
      n += int'(m_full[i]);
    end
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_sel", 32'(out_sel), 32'(m_osel));
    chk("out_data", 32'(out_data), m_ov ? 32'(m_data[m_osel]) : 32'd0);
    chk("slot_full", 32'(slot_full), 32'(f));
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(!m_full[in_sel]));
  endtask

  // Drive one cycle's inputs and sample/check at the falling edge
  task automatic drive(input bit r, input bit iv, input bit [1:0] s, input bit [15:0] d,
                       input bit ordy);
    rst = r;
    in_valid = iv;
    in_sel = s;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit r, input bit iv, input bit [1:0] s, input bit [15:0] d,
                     input bit ordy);
    drive(r, iv, s, d, ordy);
    advance();
  endtask

  typedef struct {
    bit        iv;
    bit [1:0]  sel;
    bit [15:0] data;
    bit        ordy;
    bit        e_ov;
    bit [1:0]  e_sel;
    bit [15:0] e_data;
    bit [2:0]  e_cnt;
    bit [3:0]  e_full;
    bit        e_irdy;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // iv sel data ordy | ov sel data cnt full irdy
    tbl[0]  = '{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[1]  = '{0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[2]  = '{0, 2, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[3]  = '{0, 3, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[4]  = '{1, 2, 16'hFFFF, 1, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[5]  = '{0, 0, 16'h0000, 1, 1, 2, 16'hFFFF, 1, 4'b0100, 1};
    tbl[6]  = '{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[7]  = '{1, 0, 16'h0001, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};
    tbl[8]  = '{1, 1, 16'h0002, 0, 1, 0, 16'h0001, 1, 4'b0001, 1};
    tbl[9]  = '{1, 2, 16'h0004, 0, 1, 0, 16'h0001, 2, 4'b0011, 1};
    tbl[10] = '{1, 3, 16'h0008, 0, 1, 0, 16'h0001, 3, 4'b0111, 1};
    tbl[11] = '{1, 1, 16'hDEAD, 0, 1, 0, 16'h0001, 4, 4'b1111, 0};
    tbl[12] = '{0, 3, 16'h0000, 1, 1, 0, 16'h0001, 4, 4'b1111, 0};
    tbl[13] = '{0, 0, 16'h0000, 1, 1, 1, 16'h0002, 3, 4'b1110, 1};
    tbl[14] = '{0, 0, 16'h0000, 1, 1, 2, 16'h0004, 2, 4'b1100, 1};
    tbl[15] = '{0, 0, 16'h0000, 1, 1, 3, 16'h0008, 1, 4'b1000, 1};
    tbl[16] = '{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b0000, 1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Directed table: reset idle, single pass, round-robin fill and drain
    for (int i = 0; i < 17; i++) begin
      drive(0, tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d out_sel", i), 32'(out_sel), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d slot_full", i), 32'(slot_full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
      advance();
    end

    // Hold stability: slot 3 presented and stalled, slot 0 written behind it
    cyc(0, 1, 3, 16'hA5A5, 0);
    drive(0, 1, 0, 16'h1234, 0);
    chk("hold sel t1", 32'(out_sel), 32'd3);
    chk("hold data t1", 32'(out_data), 32'hA5A5);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, 0);
      chk("hold sel", 32'(out_sel), 32'd3);
      chk("hold data", 32'(out_data), 32'hA5A5);
      advance();
    end
    drive(0, 0, 0, 16'h0, 1);
    chk("hold fire sel", 32'(out_sel), 32'd3);
    advance();
    drive(0, 0, 0, 16'h0, 1);
    chk("hold next sel", 32'(out_sel), 32'd0);
    chk("hold next data", 32'(out_data), 32'h1234);
    advance();

    // Collision: draining slot 1 still refuses a write to slot 1 that cycle
    cyc(0, 1, 1, 16'h5A5A, 0);
    drive(0, 1, 1, 16'h7777, 1);
    chk("coll in_ready busy", 32'(in_ready), 32'd0);
    chk("coll data", 32'(out_data), 32'h5A5A);
    advance();
    drive(0, 1, 1, 16'h7777, 0);
    chk("coll in_ready free", 32'(in_ready), 32'd1);
    chk("coll not taken", 32'(out_valid), 32'd0);
    advance();
    drive(0, 0, 1, 16'h0, 1);
    chk("coll accepted sel", 32'(out_sel), 32'd1);
    chk("coll accepted data", 32'(out_data), 32'h7777);
    advance();

    // Pointer after draining slot 2 is 3, so slot 3 beats slot 0
    cyc(0, 1, 2, 16'h1111, 0);
    cyc(0, 1, 0, 16'h2222, 0);
    cyc(0, 1, 3, 16'h3333, 0);
    drive(0, 0, 0, 16'h0, 1);
    chk("rr first sel", 32'(out_sel), 32'd2);
    advance();
    drive(0, 0, 0, 16'h0, 1);
    chk("rr after 2 sel", 32'(out_sel), 32'd3);
    chk("rr after 2 data", 32'(out_data), 32'h3333);
    advance();
    drive(0, 0, 0, 16'h0, 1);
    chk("rr wrap sel", 32'(out_sel), 32'd0);
    advance();

    // Mid-operation reset with three slots full and output stalled
    cyc(0, 1, 0, 16'hAAAA, 0);
    cyc(0, 1, 1, 16'hBBBB, 0);
    cyc(0, 1, 2, 16'hCCCC, 0);
    cyc(1, 1, 3, 16'hBEEF, 1);
    for (int s = 0; s < 4; s++) begin
      drive(0, 0, 2'(s), 16'h0, 1);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", 32'(out_data), 32'd0);
      chk("rst out_sel", 32'(out_sel), 32'd0);
      chk("rst count", 32'(count), 32'd0);
      chk("rst slot_full", 32'(slot_full), 32'd0);
      advance();
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          16'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
